// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the ALU scheduler
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index width that stays at least one bit wide for degenerate counts
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NREQ_DEF  = 4;
    localparam int ID_W      = idx_w(NREQ_DEF);
    localparam int ALU_OP_W  = 4;
    localparam int ALU_OPC_W = 3;
    localparam int ALU_RES_W = 8;
    // Latency counter holds ALU_LAT-1, ALU_LAT is at most 15
    localparam int LAT_W     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting at ptr
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int IW = ID_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Search upward from ptr with wrap; the first requester found wins
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler sharing one ALU between requesters
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int OP_W    = ALU_OP_W,
    parameter int OPC_W   = ALU_OPC_W,
    parameter int RES_W   = ALU_RES_W,
    parameter int ALU_LAT = 1,
    localparam int IW     = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OP_W-1:0]  req_op1,
    input  logic [NREQ*OP_W-1:0]  req_op2,
    input  logic [NREQ*OPC_W-1:0] req_opcode,
    output logic [OP_W-1:0]       alu_op1,
    output logic [OP_W-1:0]       alu_op2,
    output logic [OPC_W-1:0]      alu_opcode,
    input  logic [RES_W-1:0]      alu_res,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IW-1:0]         resp_id,
    output logic [RES_W-1:0]      resp_data,
    output logic                  busy
);

    state_e             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [OP_W-1:0]    alu_op1_q, alu_op1_d;
    logic [OP_W-1:0]    alu_op2_q, alu_op2_d;
    logic [OPC_W-1:0]   alu_opcode_q, alu_opcode_d;
    logic [IW-1:0]      resp_id_q, resp_id_d;
    logic [RES_W-1:0]   resp_data_q, resp_data_d;
    logic               resp_valid_q, resp_valid_d;

    logic [NREQ-1:0]    arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Grant only while idle; gated by rstn so nothing is accepted during reset
    assign req_ready  = (state_q == IDLE && rstn) ? arb_gnt : '0;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_opcode = alu_opcode_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != IDLE);

    // Next-state: grant in IDLE, count out the ALU latency, hold the response
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lat_cnt_d    = lat_cnt_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_opcode_d = alu_opcode_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    alu_op1_d    = req_op1[int'(arb_idx)*OP_W +: OP_W];
                    alu_op2_d    = req_op2[int'(arb_idx)*OP_W +: OP_W];
                    alu_opcode_d = req_opcode[int'(arb_idx)*OPC_W +: OPC_W];
                    resp_id_d    = arb_idx;
                    rr_ptr_d     = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + IW'(1);
                    lat_cnt_d    = LAT_W'(ALU_LAT - 1);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt_q == '0) begin
                    resp_data_d  = alu_res;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lat_cnt_q    <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_opcode_q <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lat_cnt_q    <= lat_cnt_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_opcode_q <= alu_opcode_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched
module tb_alu_sched;

    localparam int N   = 4;
    localparam int OW  = 4;
    localparam int CW  = 3;
    localparam int RW  = 8;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*OW-1:0]   req_op1;
    logic [N*OW-1:0]   req_op2;
    logic [N*CW-1:0]   req_opcode;
    logic [OW-1:0]     alu_op1;
    logic [OW-1:0]     alu_op2;
    logic [CW-1:0]     alu_opcode;
    logic [RW-1:0]     alu_res;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [RW-1:0]     resp_data;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sched #(
        .NREQ    (N),
        .OP_W    (OW),
        .OPC_W   (CW),
        .RES_W   (RW),
        .ALU_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_opcode (req_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opcode (alu_opcode),
        .alu_res    (alu_res),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    // Stand-in ALU, combinational so its result is ready after one cycle
    function automatic logic [RW-1:0] alu_f(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                            input logic [CW-1:0] op);
        logic [RW-1:0] ea, eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return ea & eb;
            3'd3:    return ea | eb;
            3'd4:    return ea ^ eb;
            3'd5:    return ea * eb;
            3'd6:    return {a, b};
            default: return ~{a, b};
        endcase
    endfunction

    assign alu_res = alu_f(alu_op1, alu_op2, alu_opcode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: one job at a time, round-robin from m_ptr, response
    // visible LAT cycles after the grant edge until the consumer takes it
    int            m_ptr = 0, m_busy = 0, m_age = 0, m_id = 0;
    logic [OW-1:0] m_op1 = '0, m_op2 = '0;
    logic [CW-1:0] m_opc = '0;
    logic [RW-1:0] m_data = '0;

    int            g_id[$], g_cyc[$], r_id[$], rise_cyc[$];
    logic [RW-1:0] r_data[$];
    logic [N-1:0]  last_ready = '0;
    logic          prev_rv = 1'b0;
    int            cyc = 0;

    // Compare every cycle on the falling edge, then advance the model
    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic         e_rv;
        int           w;
        cyc++;
        last_ready = req_ready;
        e_ready = '0;
        e_rv = 1'b0;
        w = -1;
        if (!rstn) begin
            m_ptr = 0; m_busy = 0; m_age = 0; m_id = 0;
            m_op1 = '0; m_op2 = '0; m_opc = '0; m_data = '0;
        end else begin
            if (m_busy == 0)
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) e_ready[w] = 1'b1;
            e_rv = (m_busy != 0) && (m_age >= LAT);
        end
        chk("req_ready", req_ready, e_ready);
        chk("busy", busy, m_busy);
        chk("resp_valid", resp_valid, e_rv);
        chk("alu_op1", alu_op1, m_op1);
        chk("alu_op2", alu_op2, m_op2);
        chk("alu_opcode", alu_opcode, m_opc);
        chk("resp_id", resp_id, m_id);
        chk("resp_data", resp_data, m_data);
        if (rstn) begin
            for (int i = 0; i < N; i++)
                if (req_ready[i] && req_valid[i]) begin
                    g_id.push_back(i);
                    g_cyc.push_back(cyc);
                end
            if (resp_valid && !prev_rv) rise_cyc.push_back(cyc);
            if (resp_valid && resp_ready) begin
                r_id.push_back(int'(resp_id));
                r_data.push_back(resp_data);
            end
            if (w >= 0) begin
                m_busy = 1; m_age = 0; m_ptr = (w + 1) % N; m_id = w;
                m_op1 = req_op1[w*OW +: OW];
                m_op2 = req_op2[w*OW +: OW];
                m_opc = req_opcode[w*CW +: CW];
            end else if (m_busy != 0) begin
                if (e_rv && resp_ready) m_busy = 0;
                else begin
                    m_age++;
                    if (m_age == LAT) m_data = alu_f(m_op1, m_op2, m_opc);
                end
            end
        end
        prev_rv = resp_valid & rstn;
    end

    logic [N-1:0] oneshot;

    // Advance one cycle; one-shot requesters drop valid once accepted
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (oneshot[i] && last_ready[i]) begin
                req_valid[i] = 1'b0;
                oneshot[i] = 1'b0;
            end
    endtask

    task automatic set_op(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input logic [CW-1:0] op);
        req_op1[i*OW +: OW]    = a;
        req_op2[i*OW +: OW]    = b;
        req_opcode[i*CW +: CW] = op;
    endtask

    task automatic clear_logs();
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_data.delete(); rise_cyc.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || req_valid != '0) && n < 60) begin
            tick();
            n++;
        end
        chk({"idle_", tag}, busy, 1'b0);
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n;
        rstn = 1'b0;
        resp_ready = 1'b1;
        oneshot = '0;
        req_op1 = '0;
        req_op2 = '0;
        req_opcode = '0;
        for (int i = 0; i < N; i++) set_op(i, OW'(i + 1), OW'(2 * i + 1), CW'(i));
        req_valid = 4'b1111;

        // Reset with every requester asking
        repeat (2) tick();
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_resp_valid", resp_valid, 1'b0);

        // Round-robin with all valid continuously
        clear_logs();
        rstn = 1'b1;
        repeat (16) tick();
        req_valid = '0;
        wait_idle("rr");
        chk("rr_count", (g_id.size() >= 5), 1'b1);
        if (g_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", g_id[k], exp_rr[k]);
            for (int k = 0; k < 4; k++) chk("rr_gap", g_cyc[k+1] - g_cyc[k], LAT + 2);
        end

        // Single request from requester 2: 3 + 5
        clear_logs();
        set_op(2, 4'h3, 4'h5, 3'b000);
        oneshot[2] = 1'b1;
        req_valid = 4'b0100;
        wait_idle("single");
        chk("single_n", r_id.size(), 1);
        if (r_id.size() == 1 && g_id.size() == 1 && rise_cyc.size() == 1) begin
            chk("single_gnt", g_id[0], 2);
            chk("single_id", r_id[0], 2);
            chk("single_data", r_data[0], 8'h08);
            chk("single_lat", rise_cyc[0] - g_cyc[0], 2);
        end

        // Backpressure on the response while requester 3 waits
        clear_logs();
        resp_ready = 1'b0;
        set_op(1, 4'hA, 4'h6, 3'b001);
        oneshot[1] = 1'b1;
        req_valid = 4'b0010;
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_rv", resp_valid, 1'b1);
        set_op(3, 4'h7, 4'h2, 3'b010);
        oneshot[3] = 1'b1;
        req_valid[3] = 1'b1;
        repeat (5) begin
            tick();
            chk("bp_id", resp_id, 2'd1);
            chk("bp_data", resp_data, 8'h04);
            chk("bp_no_ready", req_ready, 4'b0000);
        end
        chk("bp_no_xfer", r_id.size(), 0);
        resp_ready = 1'b1;
        tick();
        chk("bp_one_xfer", r_id.size(), 1);
        wait_idle("bp");
        chk("bp_grants", g_id.size(), 2);
        if (g_id.size() == 2 && r_data.size() == 2) begin
            chk("bp_g0", g_id[0], 1);
            chk("bp_g1", g_id[1], 3);
            chk("bp_d1", r_data[1], 8'h02);
        end

        // Pointer wrap: serve 2 so the pointer sits at 3, then ask 0 and 1
        oneshot[2] = 1'b1;
        req_valid = 4'b0100;
        wait_idle("wrap_a");
        clear_logs();
        set_op(0, 4'h9, 4'h4, 3'b100);
        set_op(1, 4'hF, 4'h1, 3'b011);
        oneshot = 4'b0011;
        req_valid = 4'b0011;
        wait_idle("wrap_b");
        chk("wrap_n", g_id.size(), 2);
        if (g_id.size() == 2) begin
            chk("wrap_g0", g_id[0], 0);
            chk("wrap_g1", g_id[1], 1);
        end

        // Reset in the middle of an EXEC cycle
        clear_logs();
        set_op(3, 4'h5, 4'h5, 3'b101);
        oneshot[3] = 1'b1;
        req_valid = 4'b1000;
        n = 0;
        while (req_valid[3] && n < 20) begin
            tick();
            n++;
        end
        chk("mid_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_op1", alu_op1, 4'h0);
        repeat (2) tick();
        chk("mid_no_resp", rise_cyc.size(), 0);
        clear_logs();
        req_valid = 4'b1111;
        rstn = 1'b1;
        repeat (4) tick();
        chk("mid_first", (g_id.size() >= 1) ? g_id[0] : -1, 0);
        req_valid = '0;
        wait_idle("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
